// File: rtl/ucsbece154a_datapath.sv
// Multicycle RV32I datapath: PC, register file, IR/OldPC, Data/A/B/ALUOut,
// immediate extender, ALU and the unified memory address/write-data path.
// Every step is sequenced externally by the multicycle controller.
module ucsbece154a_datapath #(
    parameter logic [31:0] PC_RESET = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite_i,
    input  logic        IRWrite_i,
    input  logic        RegWrite_i,
    input  logic        AdrSrc_i,
    input  logic [1:0]  ALUSrcA_i,
    input  logic [1:0]  ALUSrcB_i,
    input  logic [1:0]  ResultSrc_i,
    input  logic [2:0]  ALUControl_i,
    input  logic [2:0]  ImmSrc_i,
    input  logic [31:0] ReadData_i,
    output logic [31:0] Adr_o,
    output logic [31:0] WriteData_o,
    output logic [6:0]  op_o,
    output logic [2:0]  funct3_o,
    output logic        funct7_o,
    output logic        zero_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] oldpc_q, oldpc_d;
    logic [31:0] data_q, data_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] rf_q [32];

    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2;
    logic [31:0] imm_ext;
    logic [31:0] src_a, src_b;
    logic [31:0] alu_result;
    logic [31:0] result;

    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign rd  = ir_q[11:7];

    // x0 is hardwired to zero on the read side; no write-to-read bypass
    assign rd1 = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rd2 = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    assign op_o        = ir_q[6:0];
    assign funct3_o    = ir_q[14:12];
    assign funct7_o    = ir_q[30];
    assign WriteData_o = b_q;
    assign Adr_o       = AdrSrc_i ? result : pc_q;
    assign zero_o      = (alu_result == '0);

    // Immediate extender, decoded from the IR according to ImmSrc
    always_comb begin
        case (ImmSrc_i)
            3'b000:  imm_ext = {{20{ir_q[31]}}, ir_q[31:20]};
            3'b001:  imm_ext = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            3'b010:  imm_ext = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            3'b011:  imm_ext = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            3'b100:  imm_ext = {ir_q[31:12], 12'b0};
            default: imm_ext = 'x;
        endcase
    end

    // ALU operand selection
    always_comb begin
        case (ALUSrcA_i)
            2'b00:   src_a = pc_q;
            2'b01:   src_a = oldpc_q;
            2'b10:   src_a = a_q;
            default: src_a = 'x;
        endcase
        case (ALUSrcB_i)
            2'b00:   src_b = b_q;
            2'b01:   src_b = imm_ext;
            2'b10:   src_b = 32'd4;
            default: src_b = 'x;
        endcase
    end

    // ALU: wrapping add/sub, bitwise and/or, signed set-less-than
    always_comb begin
        case (ALUControl_i)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            default: alu_result = 'x;
        endcase
    end

    // Result bus selection
    always_comb begin
        case (ResultSrc_i)
            2'b00:   result = aluout_q;
            2'b01:   result = data_q;
            2'b10:   result = alu_result;
            default: result = imm_ext;
        endcase
    end

    // Next-state for PC/IR/OldPC (enabled) and the always-loaded registers
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        oldpc_d  = oldpc_q;
        if (PCWrite_i) pc_d = result;
        if (IRWrite_i) begin
            ir_d    = ReadData_i;
            oldpc_d = pc_q;
        end
        data_d   = ReadData_i;
        a_d      = rd1;
        b_d      = rd2;
        aluout_d = alu_result;
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= PC_RESET;
            ir_q     <= '0;
            oldpc_q  <= '0;
            data_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            oldpc_q  <= oldpc_d;
            data_q   <= data_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

    // Register file write port; contents survive reset, x0 writes dropped
    always_ff @(posedge clk) begin
        if (!reset && RegWrite_i && (rd != 5'd0)) begin
            rf_q[rd] <= result;
        end
    end

endmodule

// File: tb/tb_ucsbece154a_datapath.sv
// Directed testbench for the multicycle RV32I datapath. The bench plays the
// controller, drives per-state control vectors and checks hand-computed results.
module tb_ucsbece154a_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite_i, IRWrite_i, RegWrite_i, AdrSrc_i;
    logic [1:0]  ALUSrcA_i, ALUSrcB_i, ResultSrc_i;
    logic [2:0]  ALUControl_i, ImmSrc_i;
    logic [31:0] ReadData_i;
    logic [31:0] Adr_o, WriteData_o;
    logic [6:0]  op_o;
    logic [2:0]  funct3_o;
    logic        funct7_o, zero_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] pc_exp;
    logic [31:0] oldpc_exp;
    logic [31:0] v;
    logic [31:0] p_save;

    ucsbece154a_datapath #(.PC_RESET(32'h0001_0000)) dut (
        .clk(clk), .reset(reset),
        .PCWrite_i(PCWrite_i), .IRWrite_i(IRWrite_i), .RegWrite_i(RegWrite_i),
        .AdrSrc_i(AdrSrc_i), .ALUSrcA_i(ALUSrcA_i), .ALUSrcB_i(ALUSrcB_i),
        .ResultSrc_i(ResultSrc_i), .ALUControl_i(ALUControl_i), .ImmSrc_i(ImmSrc_i),
        .ReadData_i(ReadData_i), .Adr_o(Adr_o), .WriteData_o(WriteData_o),
        .op_o(op_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .zero_o(zero_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input logic pcw, input logic irw, input logic rw, input logic adr,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs,
                        input logic [2:0] alu, input logic [2:0] imm);
        PCWrite_i = pcw; IRWrite_i = irw; RegWrite_i = rw; AdrSrc_i = adr;
        ALUSrcA_i = sa; ALUSrcB_i = sb; ResultSrc_i = rs;
        ALUControl_i = alu; ImmSrc_i = imm;
    endtask

    task automatic idle();
        ctrl(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    endtask

    // Fetch state: PC+4 -> PC, memory word -> IR, old PC -> OldPC
    task automatic fetch(input logic [31:0] instr);
        ctrl(1, 1, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000);
        ReadData_i = instr;
        tick();
        oldpc_exp = pc_exp;
        pc_exp    = pc_exp + 32'd4;
        idle();
    endtask

    // Decode state: OldPC + imm -> ALUOut
    task automatic decode(input logic [2:0] imm);
        ctrl(0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, imm);
        tick();
        idle();
    endtask

    // Observe rf[r]: load IR with rs1=r, rs2=x0, let A/B load, expose A+0 on Adr_o
    task automatic read_reg(input logic [4:0] r, output logic [31:0] val);
        ctrl(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        ReadData_i = {12'b0, r, 3'b000, 5'b0, 7'h13};
        tick();
        idle();
        tick();
        ctrl(0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000);
        #1;
        val = Adr_o;
        idle();
    endtask

    // Write rf[r]=val through the Data register path
    task automatic write_reg(input logic [4:0] r, input logic [31:0] val);
        ctrl(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        ReadData_i = {12'b0, 5'b0, 3'b000, r, 7'h13};
        tick();
        idle();
        ReadData_i = val;
        tick();
        ctrl(0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        ReadData_i = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pc_exp = 32'h0001_0000;
        #1;
        n_vec++; if (Adr_o !== 32'h0001_0000) begin n_err++; $display("FAIL reset_pc: got %h want %h", Adr_o, 32'h0001_0000); end
        n_vec++; if (op_o !== 7'h00) begin n_err++; $display("FAIL reset_op: got %h want 00", op_o); end
        n_vec++; if (funct3_o !== 3'd0 || funct7_o !== 1'b0) begin n_err++; $display("FAIL reset_funct: got %0d/%0d want 0/0", funct3_o, funct7_o); end
        n_vec++; if (WriteData_o !== 32'h0) begin n_err++; $display("FAIL reset_b: got %h want 0", WriteData_o); end
    endtask

    task automatic test_fetch_addi();
        ctrl(1, 1, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000);
        ReadData_i = 32'h0050_0093;
        #1;
        n_vec++; if (Adr_o !== 32'h0001_0000) begin n_err++; $display("FAIL fetch_adr: got %h want %h", Adr_o, 32'h0001_0000); end
        tick();
        oldpc_exp = pc_exp;
        pc_exp = pc_exp + 32'd4;
        idle();
        #1;
        n_vec++; if (Adr_o !== 32'h0001_0004) begin n_err++; $display("FAIL fetch_pc: got %h want %h", Adr_o, 32'h0001_0004); end
        n_vec++; if (op_o !== 7'h13 || funct3_o !== 3'd0) begin n_err++; $display("FAIL fetch_ir: got op=%h f3=%0d want op=13 f3=0", op_o, funct3_o); end
        // B still holds rf[x0]=0, so OldPC+B exposes OldPC
        ctrl(0, 0, 0, 1, 2'b01, 2'b00, 2'b10, 3'b000, 3'b000);
        #1;
        n_vec++; if (Adr_o !== 32'h0001_0000) begin n_err++; $display("FAIL fetch_oldpc: got %h want %h", Adr_o, 32'h0001_0000); end
        decode(3'b000);
        ctrl(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000);   // ExecuteI
        tick();
        ctrl(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);   // ALUWB
        tick();
        idle();
        read_reg(5'd1, v);
        n_vec++; if (v !== 32'd5) begin n_err++; $display("FAIL addi_x1: got %h want %h", v, 32'd5); end
    endtask

    task automatic test_x0_and_same_cycle();
        write_reg(5'd0, 32'h0000_DEAD);
        read_reg(5'd0, v);
        n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL x0_write: got %h want 0", v); end
        write_reg(5'd2, 32'h11);
        // IR: rd=x2, rs1=x2, rs2=x0
        ctrl(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        ReadData_i = {12'b0, 5'd2, 3'b000, 5'd2, 7'h13};
        tick();
        idle();
        ReadData_i = 32'h22;
        tick();
        ctrl(0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000);
        tick();
        ctrl(0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000);
        #1;
        n_vec++; if (Adr_o !== 32'h11) begin n_err++; $display("FAIL same_cycle_a: got %h want %h", Adr_o, 32'h11); end
        idle();
        read_reg(5'd2, v);
        n_vec++; if (v !== 32'h22) begin n_err++; $display("FAIL same_cycle_wr: got %h want %h", v, 32'h22); end
    endtask

    task automatic test_beq();
        write_reg(5'd1, 32'd7);
        write_reg(5'd2, 32'd7);
        p_save = pc_exp;
        fetch(32'hFE20_8CE3);                                     // beq x1,x2,-8
        #1;
        n_vec++; if (op_o !== 7'h63 || funct7_o !== 1'b1) begin n_err++; $display("FAIL beq_decode: got op=%h f7=%0d want op=63 f7=1", op_o, funct7_o); end
        decode(3'b010);
        ctrl(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001, 3'b010);
        #1;
        n_vec++; if (zero_o !== 1'b1) begin n_err++; $display("FAIL beq_zero_taken: got %0d want 1", zero_o); end
        PCWrite_i = 1'b1;
        tick();
        pc_exp = p_save - 32'd8;
        idle();
        #1;
        n_vec++; if (Adr_o !== pc_exp) begin n_err++; $display("FAIL beq_pc_taken: got %h want %h", Adr_o, pc_exp); end
        write_reg(5'd2, 32'd8);
        p_save = pc_exp;
        fetch(32'hFE20_8CE3);
        decode(3'b010);
        ctrl(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001, 3'b010);
        #1;
        n_vec++; if (zero_o !== 1'b0) begin n_err++; $display("FAIL beq_zero_not: got %0d want 0", zero_o); end
        tick();
        idle();
        #1;
        n_vec++; if (Adr_o !== p_save + 32'd4) begin n_err++; $display("FAIL beq_pc_not: got %h want %h", Adr_o, p_save + 32'd4); end
    endtask

    task automatic test_lw_sw();
        write_reg(5'd1, 32'd5);
        fetch(32'h0010_2223);                                     // sw x1,4(x0)
        decode(3'b001);
        ctrl(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b001);   // MemAdr
        tick();
        ctrl(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001);   // MemWrite
        #1;
        n_vec++; if (Adr_o !== 32'd4) begin n_err++; $display("FAIL sw_adr: got %h want %h", Adr_o, 32'd4); end
        n_vec++; if (WriteData_o !== 32'd5) begin n_err++; $display("FAIL sw_data: got %h want %h", WriteData_o, 32'd5); end
        tick();
        idle();
        fetch(32'h0080_2183);                                     // lw x3,8(x0)
        decode(3'b000);
        ctrl(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000);   // MemAdr
        tick();
        ctrl(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);   // MemRead
        ReadData_i = 32'h1234_5678;
        #1;
        n_vec++; if (Adr_o !== 32'd8) begin n_err++; $display("FAIL lw_adr: got %h want %h", Adr_o, 32'd8); end
        tick();
        ctrl(0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000);   // MemWB
        tick();
        idle();
        read_reg(5'd3, v);
        n_vec++; if (v !== 32'h1234_5678) begin n_err++; $display("FAIL lw_rd: got %h want %h", v, 32'h1234_5678); end
    endtask

    task automatic test_alu_slt();
        logic [2:0]  ops  [4];
        logic [31:0] exps [4];
        ops[0] = 3'b101; exps[0] = 32'd1;            // slt -1 < 1
        ops[1] = 3'b001; exps[1] = 32'hFFFF_FFFE;    // sub
        ops[2] = 3'b010; exps[2] = 32'd1;            // and
        ops[3] = 3'b011; exps[3] = 32'hFFFF_FFFF;    // or
        write_reg(5'd4, 32'hFFFF_FFFF);
        write_reg(5'd5, 32'd1);
        fetch(32'h0052_2333);                                     // slt x6,x4,x5
        #1;
        n_vec++; if (op_o !== 7'h33 || funct3_o !== 3'd2) begin n_err++; $display("FAIL slt_decode: got op=%h f3=%0d want op=33 f3=2", op_o, funct3_o); end
        decode(3'b000);
        for (int i = 0; i < 4; i++) begin
            ctrl(0, 0, 0, 1, 2'b10, 2'b00, 2'b10, ops[i], 3'b000);
            #1;
            n_vec++; if (Adr_o !== exps[i]) begin n_err++; $display("FAIL alu_op%0d: got %h want %h", ops[i], Adr_o, exps[i]); end
        end
        ctrl(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b101, 3'b000);   // ExecuteR
        tick();
        ctrl(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);   // ALUWB
        tick();
        idle();
        read_reg(5'd6, v);
        n_vec++; if (v !== 32'd1) begin n_err++; $display("FAIL slt_rd: got %h want 1", v); end
    endtask

    task automatic test_lui_jal();
        fetch(32'hABCD_E0B7);                                     // lui x1,0xABCDE
        decode(3'b100);
        ctrl(0, 0, 1, 1, 2'b00, 2'b00, 2'b11, 3'b000, 3'b100);
        #1;
        n_vec++; if (Adr_o !== 32'hABCD_E000) begin n_err++; $display("FAIL lui_result: got %h want %h", Adr_o, 32'hABCD_E000); end
        tick();
        idle();
        read_reg(5'd1, v);
        n_vec++; if (v !== 32'hABCD_E000) begin n_err++; $display("FAIL lui_rd: got %h want %h", v, 32'hABCD_E000); end
        p_save = pc_exp;
        fetch(32'h0100_03EF);                                     // jal x7,16
        decode(3'b011);
        ctrl(1, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'b000, 3'b011);   // JAL
        tick();
        ctrl(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);   // ALUWB
        tick();
        idle();
        pc_exp = p_save + 32'd16;
        #1;
        n_vec++; if (Adr_o !== pc_exp) begin n_err++; $display("FAIL jal_pc: got %h want %h", Adr_o, pc_exp); end
        read_reg(5'd7, v);
        n_vec++; if (v !== p_save + 32'd4) begin n_err++; $display("FAIL jal_rd: got %h want %h", v, p_save + 32'd4); end
    endtask

    task automatic test_reset_mid();
        // IR holds rd=x7 and Data a junk value, then reset with every write enabled
        ctrl(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        ReadData_i = {12'b0, 5'b0, 3'b000, 5'd7, 7'h13};
        tick();
        idle();
        ReadData_i = 32'hBAD0_BAD0;
        tick();
        ctrl(1, 1, 1, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000);
        ReadData_i = 32'h0050_0093;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        pc_exp = 32'h0001_0000;
        #1;
        n_vec++; if (Adr_o !== 32'h0001_0000) begin n_err++; $display("FAIL rst_mid_pc: got %h want %h", Adr_o, 32'h0001_0000); end
        n_vec++; if (op_o !== 7'h00 || funct3_o !== 3'd0 || funct7_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_ir: got op=%h f3=%0d f7=%0d want 0", op_o, funct3_o, funct7_o); end
        read_reg(5'd7, v);
        n_vec++; if (v !== p_save + 32'd4) begin n_err++; $display("FAIL rst_mid_rf: got %h want %h", v, p_save + 32'd4); end
    endtask

    initial begin
        reset = 1'b1;
        ReadData_i = '0;
        idle();
        test_reset();
        test_fetch_addi();
        test_x0_and_same_cycle();
        test_beq();
        test_lw_sw();
        test_alu_slt();
        test_lui_jal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
